// File: rtl/syn_fifo_afe.sv
// ---------------------------------------------------------------------------
// syn_fifo_afe
// Single-clock FIFO buffering traffic between 8051 peripherals (UART, SPI,
// SFR bridges). It exports occupancy and free-space counts, programmable
// almost-full/almost-empty flags, and sticky overflow/underflow error flags.
//
// Build option:
//   SYN_FIFO_FWFT_EN  defined   -> first-word-fall-through. r_data shows the
//                                  head entry combinationally and r_en pops it.
//                     undefined -> r_data is a register loaded at the edge
//                                  that accepts a read (1-cycle latency).
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   w_en, w_data     write request and write data
//   r_en, r_data     read request (pop) and read data
//   is_empty/is_full count == 0 / count == FIFO_DEPTH
//   almost_empty     count <= AEMPTY_TH
//   almost_full      count >= AFULL_TH
//   data_avail       current count
//   room_avail       FIFO_DEPTH - count
//   overflow         sticky: a write was dropped because the FIFO was full
//   underflow        sticky: a read was attempted while the FIFO was empty
//   clr_err          synchronous clear of both sticky flags (a set wins)
// ---------------------------------------------------------------------------
module syn_fifo_afe #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  is_empty,
    output logic                  is_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   data_avail,
    output logic [ADDR_WIDTH:0]   room_avail,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = CW'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = CW'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // A write into a full FIFO is still accepted when a read frees the slot
    // in the same cycle; a read from an empty FIFO is never accepted.
    always_comb begin
        wr_acc      = w_en && (!is_full || r_en);
        rd_acc      = r_en && !is_empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // New error events take priority over a coincident clear.
        overflow_d  = (overflow_q  && !clr_err) || (w_en && is_full && !r_en);
        underflow_d = (underflow_q && !clr_err) || (r_en && is_empty);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    // Head entry is always visible; contents are meaningless while empty.
    assign r_data = mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

    // Holds the last popped word until the next accepted read.
    always_comb begin
        r_data_d = r_data_q;
        if (rd_acc) r_data_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_data_q <= '0;
        else     r_data_q <= r_data_d;
    end

    assign r_data = r_data_q;
`endif

    assign is_empty     = (count_q == '0);
    assign is_full      = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign data_avail   = count_q;
    assign room_avail   = DEPTH_C - count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
